// File: rtl/system_pkg.sv
// Shared opcode encoding and result-flag type for the registered ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package system_pkg;

    // 74381-style function select encoding
    typedef enum logic [2:0] {
        OP_CLR = 3'b000,
        OP_BMA = 3'b001,
        OP_AMB = 3'b010,
        OP_ADD = 3'b011,
        OP_XOR = 3'b100,
        OP_OR  = 3'b101,
        OP_AND = 3'b110,
        OP_SET = 3'b111
    } op_t;

    // Status flags that travel with the result
    typedef struct packed {
        logic cout;
        logic ovf;
    } flags_t;

    // True for the three codes that route through the adder
    function automatic logic is_arith(input op_t op);
        return (op == OP_BMA) || (op == OP_AMB) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/system_adder.sv
// WIDTH-bit adder with carry-in, returning sum, carry-out and signed overflow.
// Latency: combinational.
// Backpressure: none.
module system_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Sum with carry; overflow when like-signed inputs give an opposite-signed result
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        ovf         = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/system.sv
// Registered 74381-style ALU; optional registered zero flag when SYSTEM_ZERO_FLAG_EN is defined.
// Latency: 1 cycle from sampled inputs to F/Cout/overflow.
// Backpressure: none; a new op every cycle, en_n=1 simply holds the outputs.
module system
    import system_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic [2:0]       S,
    input  logic             en_n,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             overflow,
    input  logic             clk,
    input  logic             rst
`ifdef SYSTEM_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    op_t              op;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic [WIDTH-1:0] f_nxt;
    flags_t           flags_nxt;

    assign op = op_t'(S);

    // Steer operands into the adder; subtraction inverts one input and relies on C_in for the +1
    always_comb begin
        add_a   = A;
        add_b   = B;
        add_cin = 1'b0;
        case (op)
            OP_BMA: begin
                add_a   = B;
                add_b   = ~A;
                add_cin = C_in;
            end
            OP_AMB: begin
                add_a   = A;
                add_b   = ~B;
                add_cin = C_in;
            end
            OP_ADD: begin
                add_cin = C_in;
            end
            default: ;
        endcase
    end

    system_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Select next result; flags are meaningful only for adder-based codes
    always_comb begin
        f_nxt     = '0;
        flags_nxt = '0;
        if (is_arith(op)) begin
            f_nxt          = add_sum;
            flags_nxt.cout = add_cout;
            flags_nxt.ovf  = add_ovf;
        end else begin
            case (op)
                OP_XOR:  f_nxt = A ^ B;
                OP_OR:   f_nxt = A | B;
                OP_AND:  f_nxt = A & B;
                OP_SET:  f_nxt = '1;
                default: f_nxt = '0;
            endcase
        end
    end

    // Output register: reset wins over enable, en_n=1 holds
    always_ff @(posedge clk) begin
        if (rst) begin
            F        <= '0;
            Cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (!en_n) begin
            F        <= f_nxt;
            Cout     <= flags_nxt.cout;
            overflow <= flags_nxt.ovf;
        end
    end

`ifdef SYSTEM_ZERO_FLAG_EN
    // Zero flag registered alongside F under the same reset/enable rules
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
        end else if (!en_n) begin
            zero <= (f_nxt == '0);
        end
    end
`endif

endmodule

// File: tb/tb_system.sv
// Scoreboard bench for the registered ALU: expectations queued at drive time, checked after the capture edge.
// Latency: expects results one clock after the inputs are driven.
// Backpressure: none exercised beyond en_n hold.
module tb_system;

    logic [31:0] A;
    logic [31:0] B;
    logic        C_in;
    logic [2:0]  S;
    logic        en_n;
    logic [31:0] F;
    logic        Cout;
    logic        overflow;
    logic        clk;
    logic        rst;
`ifdef SYSTEM_ZERO_FLAG_EN
    logic        zero;
`endif

    typedef struct {
        logic [31:0] f;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    exp_t  cur;
    int    n_checks = 0;
    int    n_errors = 0;

    system #(.WIDTH(32)) dut (
        .A        (A),
        .B        (B),
        .C_in     (C_in),
        .S        (S),
        .en_n     (en_n),
        .F        (F),
        .Cout     (Cout),
        .overflow (overflow),
        .clk      (clk),
        .rst      (rst)
`ifdef SYSTEM_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: wide unsigned sum for carry, signed 64-bit sum for overflow
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic [2:0] s);
        exp_t        e;
        logic [31:0] x;
        logic [31:0] y;
        logic [32:0] wide;
        longint      ss;
        e.f = 32'h0; e.cout = 1'b0; e.ovf = 1'b0;
        x = a; y = b;
        case (s)
            3'b000: e.f = 32'h0;
            3'b001, 3'b010, 3'b011: begin
                if (s == 3'b001) begin x = b; y = ~a; end
                if (s == 3'b010) begin x = a; y = ~b; end
                wide   = {1'b0, x} + {1'b0, y} + {32'h0, cin};
                e.f    = wide[31:0];
                e.cout = wide[32];
                ss     = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
                e.ovf  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            3'b100: e.f = a ^ b;
            3'b101: e.f = a | b;
            3'b110: e.f = a & b;
            default: e.f = 32'hFFFF_FFFF;
        endcase
        e.zero = (e.f == 32'h0);
        return e;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then check after the edge
    task automatic step(input string tag, input logic r, input logic en,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [2:0] s);
        exp_t  e;
        string t;
        @(negedge clk);
        rst = r; en_n = en; A = a; B = b; C_in = cin; S = s;
        if (r)       begin e.f = 32'h0; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0; end
        else if (en) e = cur;
        else         e = model(a, b, cin, s);
        cur = e;
        sb.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        t = tag_q.pop_front();
        check({t, ".F"}, F, e.f);
        check({t, ".Cout"}, {31'h0, Cout}, {31'h0, e.cout});
        check({t, ".ovf"}, {31'h0, overflow}, {31'h0, e.ovf});
`ifdef SYSTEM_ZERO_FLAG_EN
        check({t, ".zero"}, {31'h0, zero}, {31'h0, e.zero});
`endif
    endtask

    initial begin
        rst = 1'b1; en_n = 1'b0; A = '0; B = '0; C_in = 1'b0; S = 3'b000;
        cur.f = 32'h0; cur.cout = 1'b0; cur.ovf = 1'b0; cur.zero = 1'b0;

        step("rst0", 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, 3'b011);
        step("rst1", 1'b1, 1'b1, 32'd5, 32'd7, 1'b1, 3'b111);

        // Directed arithmetic
        step("add20_19",  1'b0, 1'b0, 32'd20, 32'd19, 1'b0, 3'b011);
        step("amb16_8",   1'b0, 1'b0, 32'd16, 32'd8,  1'b1, 3'b010);
        step("bma16_8",   1'b0, 1'b0, 32'd16, 32'd8,  1'b1, 3'b001);
        // Directed logic
        step("and22_13",  1'b0, 1'b0, 32'd22, 32'd13, 1'b0, 3'b110);
        step("or22_13",   1'b0, 1'b0, 32'd22, 32'd13, 1'b0, 3'b101);
        step("xor22_13",  1'b0, 1'b0, 32'd22, 32'd13, 1'b1, 3'b100);
        step("clr",       1'b0, 1'b0, 32'd22, 32'd13, 1'b1, 3'b000);
        step("set",       1'b0, 1'b0, 32'd22, 32'd13, 1'b1, 3'b111);
        // Overflow / carry boundaries
        step("add_ovf",   1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 3'b011);
        step("add_carry", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'b011);
        step("amb_ovf",   1'b0, 1'b0, 32'h8000_0000, 32'h1, 1'b1, 3'b010);
        step("add_cin",   1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0, 1'b1, 3'b011);
        // Hold while disabled, then reset regardless of enable, then immediate resume
        step("hold0",     1'b0, 1'b1, 32'd3, 32'd4, 1'b0, 3'b011);
        step("hold1",     1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 3'b111);
        step("pre_rst",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'b011);
        step("rst_dis",   1'b1, 1'b1, 32'd9, 32'd9, 1'b0, 3'b111);
        step("set2",      1'b0, 1'b0, 32'd1, 32'd2, 1'b0, 3'b111);
        step("rst_en",    1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 3'b111);
        step("resume",    1'b0, 1'b0, 32'd20, 32'd19, 1'b0, 3'b011);
        step("zero_clr",  1'b0, 1'b0, 32'd20, 32'd19, 1'b0, 3'b000);
        step("zero_sub",  1'b0, 1'b0, 32'd77, 32'd77, 1'b1, 3'b010);

        // Random mix, including occasional hold and reset cycles
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ((i % 5) == 0) ra = {$urandom_range(1, 0) ? 1'b1 : 1'b0, 31'h7FFF_FFFF};
            step("rand", ($urandom_range(29, 0) == 0), ($urandom_range(7, 0) == 0),
                 ra, rb, 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)));
        end

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
